// File: rtl/serv_ibus_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : serv_ibus_prefetch
// Purpose  : Single-entry instruction buffer with next-word speculative fetch
//            between the core instruction bus and a Wishbone master port.
// Revision : 1.0 - initial release
// ============================================================================
module serv_ibus_prefetch #(
    parameter RESET_STRATEGY = "MINI",
    parameter int WITH_PREFETCH = 1
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DEMAND = 2'd1;
    localparam logic [1:0] c_PREF   = 2'd2;
    localparam bit         c_RST_DATA = (RESET_STRATEGY != "NONE");
    localparam bit         c_PREFETCH = (WITH_PREFETCH != 0);

    logic [1:0]  r_state;
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic [29:0] r_pf_tag;
    logic        r_pend_hit;
    logic        r_discard;

    logic        w_req;
    logic        w_hit;
    logic        w_pf_match;
    logic        w_drop;
    logic        w_idle_hit;
    logic        w_idle_miss;
    logic        w_dem_done;
    logic        w_pf_start;
    logic        w_pf_done;
    logic        w_pf_keep;
    logic        w_pf_deliver;
    logic        w_pf_redemand;
    logic        w_fill;
    logic [1:0]  w_unused_adr_lsb;

    assign w_unused_adr_lsb = i_ibus_adr[1:0];

    // The ack cycle itself never opens a new request.
    assign w_req         = i_ibus_cyc & ~o_ibus_ack;
    assign w_hit         = r_buf_valid & (r_buf_tag == i_ibus_adr[31:2]);
    assign w_pf_match    = w_req & (r_pf_tag == i_ibus_adr[31:2]);
    assign w_drop        = r_discard | i_flush;

    assign w_idle_hit    = (r_state == c_IDLE) & w_req & w_hit;
    assign w_idle_miss   = (r_state == c_IDLE) & w_req & ~w_hit;
    assign w_dem_done    = (r_state == c_DEMAND) & o_wb_cyc & i_wb_ack;
    assign w_pf_start    = (r_state == c_PREF) & ~o_wb_cyc;
    assign w_pf_done     = (r_state == c_PREF) & o_wb_cyc & i_wb_ack;
    assign w_pf_keep     = w_pf_done & ~w_drop;
    assign w_pf_deliver  = w_pf_keep & (r_pend_hit | w_pf_match);
    assign w_pf_redemand = w_pf_done & w_drop & w_req;
    // A flushed demand still reaches the core but never lands in the buffer.
    assign w_fill        = (w_dem_done & ~r_discard & ~i_flush) | w_pf_keep;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= c_IDLE;
            r_buf_valid <= 1'b0;
            r_pend_hit  <= 1'b0;
            r_discard   <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_ibus_ack  <= 1'b0;
        end else begin
            o_ibus_ack <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_idle_hit) begin
                        o_ibus_ack <= 1'b1;
                        if (c_PREFETCH) r_state <= c_PREF;
                    end else if (w_idle_miss) begin
                        r_state  <= c_DEMAND;
                        o_wb_cyc <= 1'b1;
                    end
                end
                c_DEMAND: begin
                    if (i_flush) r_discard <= 1'b1;
                    if (w_dem_done) begin
                        o_wb_cyc   <= 1'b0;
                        o_ibus_ack <= 1'b1;
                        r_discard  <= 1'b0;
                        r_state    <= c_PREFETCH ? c_PREF : c_IDLE;
                    end
                end
                c_PREF: begin
                    if (!o_wb_cyc) begin
                        o_wb_cyc <= 1'b1;
                    end else if (i_wb_ack) begin
                        o_wb_cyc   <= 1'b0;
                        r_pend_hit <= 1'b0;
                        r_discard  <= 1'b0;
                        if (w_pf_deliver) begin
                            o_ibus_ack <= 1'b1;
                        end else if (w_pf_redemand) begin
                            r_state  <= c_DEMAND;
                            o_wb_cyc <= 1'b1;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        if (w_pf_match) r_pend_hit <= 1'b1;
                        if ((w_req & ~w_pf_match) | i_flush) r_discard <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
            if (w_fill)  r_buf_valid <= 1'b1;
            if (i_flush) r_buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst && c_RST_DATA) begin
            r_buf_tag  <= 30'd0;
            r_buf_data <= 32'd0;
            r_pf_tag   <= 30'd0;
            o_wb_adr   <= 32'd0;
            o_ibus_rdt <= 32'd0;
        end else begin
            if (w_fill) begin
                r_buf_tag  <= o_wb_adr[31:2];
                r_buf_data <= i_wb_rdt;
            end
            if (w_idle_hit)
                o_ibus_rdt <= r_buf_data;
            else if (w_dem_done | w_pf_deliver)
                o_ibus_rdt <= i_wb_rdt;
            if (w_idle_hit)
                r_pf_tag <= r_buf_tag + 30'd1;
            else if (w_dem_done | w_pf_deliver)
                r_pf_tag <= o_wb_adr[31:2] + 30'd1;
            if (w_idle_miss | w_pf_redemand)
                o_wb_adr <= {i_ibus_adr[31:2], 2'b00};
            else if (w_pf_start)
                o_wb_adr <= {r_pf_tag, 2'b00};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serv_ibus_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_serv_ibus_prefetch
// Purpose  : Cycle-by-cycle vector bench for serv_ibus_prefetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serv_ibus_prefetch;

    logic        clk = 1'b0;
    logic        i_rst, i_flush, i_ibus_cyc, i_wb_ack;
    logic [31:0] i_ibus_adr, i_wb_rdt;
    logic [31:0] o_ibus_rdt, o_wb_adr;
    logic        o_ibus_ack, o_wb_cyc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serv_ibus_prefetch #(
        .RESET_STRATEGY("MINI"),
        .WITH_PREFETCH (1)
    ) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_flush   (i_flush),
        .i_ibus_adr(i_ibus_adr),
        .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt),
        .o_ibus_ack(o_ibus_ack),
        .o_wb_adr  (o_wb_adr),
        .o_wb_cyc  (o_wb_cyc),
        .i_wb_rdt  (i_wb_rdt),
        .i_wb_ack  (i_wb_ack)
    );

    // One row = inputs held across one rising edge, outputs expected after it.
    typedef struct {
        logic        rst, flush, cyc;
        logic [31:0] adr;
        logic        wack;
        logic [31:0] wrdt;
        logic        e_wcyc;
        logic [31:0] e_wadr;
        logic        e_ack;
        logic [31:0] e_rdt;
    } vec_t;

    localparam int c_NVEC = 40;
    vec_t tbl [c_NVEC];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic vec_t V(input logic rst, flush, cyc, input logic [31:0] adr,
                               input logic wack, input logic [31:0] wrdt,
                               input logic e_wcyc, input logic [31:0] e_wadr,
                               input logic e_ack, input logic [31:0] e_rdt);
        vec_t v;
        v.rst = rst; v.flush = flush; v.cyc = cyc; v.adr = adr;
        v.wack = wack; v.wrdt = wrdt;
        v.e_wcyc = e_wcyc; v.e_wadr = e_wadr; v.e_ack = e_ack; v.e_rdt = e_rdt;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s row %0d: got %08h want %08h", name, row, got, want);
        end
    endtask

    task automatic step(input vec_t v, input int row);
        i_rst      = v.rst;
        i_flush    = v.flush;
        i_ibus_cyc = v.cyc;
        i_ibus_adr = v.adr;
        i_wb_ack   = v.wack;
        i_wb_rdt   = v.wrdt;
        @(posedge clk);
        #1;
        check("wb_cyc", row, {31'd0, o_wb_cyc}, {31'd0, v.e_wcyc});
        if (v.e_wcyc) check("wb_adr", row, o_wb_adr, v.e_wadr);
        check("ibus_ack", row, {31'd0, o_ibus_ack}, {31'd0, v.e_ack});
        if (v.e_ack) check("ibus_rdt", row, o_ibus_rdt, v.e_rdt);
    endtask

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_ibus_cyc = 1'b0; i_ibus_adr = '0;
        i_wb_ack = 1'b0; i_wb_rdt = '0;

        //             rst fl cyc adr           wack wrdt                 ecyc eadr          eack erdt
        tbl[0]  = V(1, 0, 0, 32'h0,        0, 32'h0,             0, 32'h0,        0, 32'h0);
        tbl[1]  = V(0, 0, 0, 32'h0,        0, 32'h0,             0, 32'h0,        0, 32'h0);
        // demand miss at 0x100, Wishbone ack three cycles after the request
        tbl[2]  = V(0, 0, 1, 32'h100,      0, 32'h0,             1, 32'h100,      0, 32'h0);
        tbl[3]  = V(0, 0, 1, 32'h100,      0, 32'h0,             1, 32'h100,      0, 32'h0);
        tbl[4]  = V(0, 0, 1, 32'h100,      0, 32'h0,             1, 32'h100,      0, 32'h0);
        tbl[5]  = V(0, 0, 1, 32'h100,      1, dat(32'h100),      0, 32'h0,        1, dat(32'h100));
        tbl[6]  = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h104,      0, 32'h0);
        tbl[7]  = V(0, 0, 0, 32'h0,        1, dat(32'h104),      0, 32'h0,        0, 32'h0);
        // sequential hit out of the buffer
        tbl[8]  = V(0, 0, 1, 32'h104,      0, 32'h0,             0, 32'h0,        1, dat(32'h104));
        tbl[9]  = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h108,      0, 32'h0);
        // request matching the in-flight prefetch
        tbl[10] = V(0, 0, 1, 32'h108,      0, 32'h0,             1, 32'h108,      0, 32'h0);
        tbl[11] = V(0, 0, 1, 32'h108,      1, dat(32'h108),      0, 32'h0,        1, dat(32'h108));
        tbl[12] = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h10C,      0, 32'h0);
        // branch away while the prefetch is in flight
        tbl[13] = V(0, 0, 1, 32'h200,      0, 32'h0,             1, 32'h10C,      0, 32'h0);
        tbl[14] = V(0, 0, 1, 32'h200,      1, dat(32'h10C),      1, 32'h200,      0, 32'h0);
        tbl[15] = V(0, 0, 1, 32'h200,      1, dat(32'h200),      0, 32'h0,        1, dat(32'h200));
        tbl[16] = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h204,      0, 32'h0);
        // flush during prefetch forces a fresh demand of the same word
        tbl[17] = V(0, 1, 0, 32'h0,        0, 32'h0,             1, 32'h204,      0, 32'h0);
        tbl[18] = V(0, 0, 1, 32'h204,      0, 32'h0,             1, 32'h204,      0, 32'h0);
        tbl[19] = V(0, 0, 1, 32'h204,      1, dat(32'h204),      1, 32'h204,      0, 32'h0);
        tbl[20] = V(0, 0, 1, 32'h204,      1, dat(32'h204),      0, 32'h0,        1, dat(32'h204));
        tbl[21] = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h208,      0, 32'h0);
        tbl[22] = V(0, 0, 0, 32'h0,        1, dat(32'h208),      0, 32'h0,        0, 32'h0);
        tbl[23] = V(0, 0, 1, 32'h208,      0, 32'h0,             0, 32'h0,        1, dat(32'h208));
        tbl[24] = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h20C,      0, 32'h0);
        tbl[25] = V(0, 0, 0, 32'h0,        1, dat(32'h20C),      0, 32'h0,        0, 32'h0);
        // flush while idle turns a would-be hit into a miss
        tbl[26] = V(0, 1, 0, 32'h0,        0, 32'h0,             0, 32'h0,        0, 32'h0);
        tbl[27] = V(0, 0, 1, 32'h20C,      0, 32'h0,             1, 32'h20C,      0, 32'h0);
        tbl[28] = V(0, 0, 1, 32'h20C,      1, dat(32'h20C),      0, 32'h0,        1, dat(32'h20C));
        tbl[29] = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h210,      0, 32'h0);
        // top-of-memory demand, next prefetch wraps to zero
        tbl[30] = V(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,             1, 32'h210,      0, 32'h0);
        tbl[31] = V(0, 0, 1, 32'hFFFFFFFC, 1, dat(32'h210),      1, 32'hFFFFFFFC, 0, 32'h0);
        tbl[32] = V(0, 0, 1, 32'hFFFFFFFC, 1, dat(32'hFFFFFFFC), 0, 32'h0,        1, dat(32'hFFFFFFFC));
        tbl[33] = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h0,        0, 32'h0);
        tbl[34] = V(0, 0, 0, 32'h0,        1, dat(32'h0),        0, 32'h0,        0, 32'h0);
        tbl[35] = V(0, 0, 1, 32'h0,        0, 32'h0,             0, 32'h0,        1, dat(32'h0));
        tbl[36] = V(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h4,        0, 32'h0);
        tbl[37] = V(0, 0, 0, 32'h0,        1, dat(32'h4),        0, 32'h0,        0, 32'h0);
        // stray Wishbone ack while idle
        tbl[38] = V(0, 0, 0, 32'h0,        1, 32'hDEADBEEF,      0, 32'h0,        0, 32'h0);
        tbl[39] = V(0, 0, 0, 32'h0,        0, 32'h0,             0, 32'h0,        0, 32'h0);

        for (int i = 0; i < c_NVEC; i++) step(tbl[i], i);

        // Reset in the middle of a demand, then a late ack, then the word
        // that was buffered before reset must miss.
        step(V(0, 0, 1, 32'h300, 0, 32'h0, 1, 32'h300, 0, 32'h0), 100);
        step(V(1, 0, 1, 32'h300, 0, 32'h0, 0, 32'h0,   0, 32'h0), 101);
        check("rst_wb_adr", 101, o_wb_adr, 32'h0);
        check("rst_ibus_rdt", 101, o_ibus_rdt, 32'h0);
        step(V(0, 0, 0, 32'h0,   1, dat(32'h300), 0, 32'h0, 0, 32'h0), 102);
        step(V(0, 0, 1, 32'h4,   0, 32'h0, 1, 32'h4, 0, 32'h0), 103);
        step(V(0, 0, 1, 32'h4,   1, dat(32'h4), 0, 32'h0, 1, dat(32'h4)), 104);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serv_ibus_prefetch.md
Name: serv_ibus_prefetch

Overview:
- Single-entry instruction prefetch buffer between the core's instruction-bus master and the external Wishbone instruction bus.
- The core-side address is the PC register shifted out by the control stage.
- Demand fetches are issued on a miss. After every delivered word, the block speculatively fetches the next sequential word (PC+4). A sequential fetch then completes in 1 cycle instead of a full bus round trip.
- Word-granular only: address bits [1:0] are ignored, and halfword alignment is handled upstream.

Parameters:
- RESET_STRATEGY, "MINI": "NONE" leaves the data/tag regs unreset. Control state (state, valid, cyc, ack) is always reset.
- WITH_PREFETCH, 1: 0 disables speculative fetch, leaving a pure 1-entry cache of the last fetched word.

Ports:
- clk, in, 1: clock. Single clock domain.
- i_rst, in, 1: reset, synchronous, active-high.
- i_flush, in, 1: invalidate buffer (fence.i). Single-cycle pulse.
- i_ibus_adr, in, 32: core fetch address. Stable while i_ibus_cyc=1.
- i_ibus_cyc, in, 1: core fetch request. Held until o_ibus_ack.
- o_ibus_rdt, out, 32: instruction word. Valid when o_ibus_ack=1.
- o_ibus_ack, out, 1: 1-cycle completion pulse, registered.
- o_wb_adr, out, 32: external address, {tag,2'b00}.
- o_wb_cyc, out, 1: external request, registered. Held until i_wb_ack.
- i_wb_rdt, in, 32: external read data.
- i_wb_ack, in, 1: external completion.

Behaviour:
- Registers:
  - state ∈ {IDLE, DEMAND, PREF}.
  - buf_valid, buf_tag[29:0], buf_data[31:0].
  - pf_tag[29:0].
  - pend_hit: core request matched the in-flight prefetch.
  - discard: in-flight result must be dropped.
- Reset:
  - state=IDLE; buf_valid, o_wb_cyc, o_ibus_ack, pend_hit and discard all 0.
  - o_wb_adr and o_ibus_rdt are 0 unless RESET_STRATEGY="NONE".
  - Reset mid-transaction drops o_wb_cyc on the next edge. A stray i_wb_ack arriving in IDLE is ignored.
- Request definition: req = i_ibus_cyc & ~o_ibus_ack. The cycle in which ack is high never starts a new request.
- hit = buf_valid & (buf_tag == i_ibus_adr[31:2]).
- IDLE:
  - req & hit: next cycle o_ibus_ack=1, o_ibus_rdt=buf_data. If WITH_PREFETCH, go to PREF with pf_tag=buf_tag+1.
  - req & ~hit: go to DEMAND; next cycle o_wb_cyc=1, o_wb_adr={i_ibus_adr[31:2],2'b00}.
- DEMAND, on i_wb_ack:
  - buf_data<=i_wb_rdt, buf_tag<=addr, buf_valid<=1.
  - Next cycle o_ibus_ack=1 with that data. o_wb_cyc falls on the same edge.
  - Then go to PREF (pf_tag=addr+1), or to IDLE if WITH_PREFETCH=0.
- PREF:
  - o_wb_cyc=1, o_wb_adr={pf_tag,2'b00}.
  - A core req with addr[31:2]==pf_tag sets pend_hit.
  - A core req with a different address, or i_flush, sets discard. A Wishbone cycle is never aborted; it is always run to i_wb_ack.
  - On i_wb_ack:
    - If ~discard: buffer <= {pf_tag, i_wb_rdt, valid=1}. If pend_hit (or a matching req in the same cycle), o_ibus_ack=1 next cycle and chain a new PREF with pf_tag+1. Otherwise go to IDLE.
    - If discard: buffer unchanged. If a req is pending, go to DEMAND for it; otherwise go to IDLE.
  - pend_hit and discard clear on leaving PREF.
- i_flush:
  - Clears buf_valid in the same edge.
  - Has priority over a simultaneous buffer fill.
  - An in-flight DEMAND still delivers to the core but does not fill the buffer.
- Arithmetic: pf_tag is 30 bits, and tag+1 wraps 0x3FFFFFFF→0.
- Core address changes while i_ibus_cyc=1 are illegal and produce undefined results.
- Latency:
  - Hit: 1 cycle after cyc.
  - Miss: o_wb_cyc rises 1 cycle after cyc; o_ibus_ack follows 1 cycle after i_wb_ack.
  - Prefetch-match: 1 cycle after i_wb_ack, or 1 cycle after cyc if the data is already buffered.

Decomposition:
- No shared package. State encoding is localparams inside the module.
- No sub-module; a single flat module.
- Tag compare and +1 stay inline.

Test Plan:
- Reset, then req 0x100 with i_wb_ack 3 cycles later:
  - o_wb_cyc rises 1 cycle after cyc, o_wb_adr=0x100.
  - o_ibus_ack rises 1 cycle after i_wb_ack, rdt=data.
  - Next cycle o_wb_cyc=1 with o_wb_adr=0x104.
- Sequential: after the prefetch of 0x104 completes, req 0x104 → o_ibus_ack 1 cycle later, no new demand; prefetch of 0x108 starts.
- Branch during prefetch: req 0x200 while PREF 0x104 is in flight:
  - 0x104 completes and is discarded (buffer tag stays 0x100).
  - Then o_wb_adr=0x200, and the ack returns 0x200 data.
- i_flush during PREF, then req 0x104 → treated as a miss: a new demand fetch of 0x104 is issued.
- Wrap: demand 0xFFFFFFFC → next prefetch o_wb_adr=0x00000000.
- i_rst asserted mid-DEMAND, then i_wb_ack arrives → o_wb_cyc=0 after the edge, no o_ibus_ack, buf_valid=0; a following req 0x100 misses.
